// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with credit-limited request issue,
// PC-tagged instruction FIFO and redirect flush with stale-response drop.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;

    logic [31:0] fifo_pc_q   [DEPTH];
    logic [31:0] fifo_data_q [DEPTH];
    logic [31:0] tag_q       [DEPTH];

    logic credit_ok;
    logic accept;
    logic push;
    logic pop;
    logic rsp_drop;

    always_comb begin
        credit_ok = ({1'b0, count_q} + {1'b0, pending_q}) < DEPTH_C;
        imem_req  = !rst && !redirect && credit_ok;
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_gnt;
        rsp_drop  = imem_rvalid && (drop_q != '0);
        push      = imem_rvalid && (drop_q == '0) && !redirect;
        pop       = inst_valid && inst_ready && !redirect;

        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pending_d  = pending_q + CW'(accept) - CW'(imem_rvalid);
        tag_wr_d   = tag_wr_q + AW'(accept);
        tag_rd_d   = tag_rd_q + AW'(imem_rvalid);

        if (redirect) begin
            // every response still in flight after this cycle is stale
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            drop_d     = pending_q - CW'(imem_rvalid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            drop_d   = drop_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[tag_wr_q] <= imem_addr;
        end
        if (push && !rst) begin
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            fifo_data_q[wr_ptr_q] <= imem_rdata;
        end
    end

    always_comb begin
        inst_valid = (count_q != '0);
        inst       = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
        inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a variable-latency
// in-order instruction memory model.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          t;
    } req_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] pc0;
        logic [31:0] pc1;
        int          lat;
        int          exp_k;
    } vec_t;

    req_t q[$];
    int   edge_n = 0;
    int   lat = 1;
    int   checks = 0;
    int   failures = 0;

    logic        s_valid, s_req, s_rv, s_gnt, s_rst, s_rdy;
    logic [31:0] s_inst, s_pc, s_addr;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock: snapshot outputs mid-cycle, then advance the memory model
    task automatic cycle();
        @(negedge clk);
        s_valid = inst_valid;
        s_inst  = inst;
        s_pc    = inst_pc;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_rv    = imem_rvalid;
        s_gnt   = imem_gnt;
        s_rst   = rst;
        s_rdy   = inst_ready;
        @(posedge clk);
        #1;
        edge_n++;
        if (s_rst) begin
            q.delete();
        end else begin
            if (s_rv && q.size() > 0) void'(q.pop_front());
            if (s_req && s_gnt) q.push_back('{a: s_addr, t: edge_n});
        end
        if (q.size() > 0 && edge_n >= q[0].t + lat - 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = dat(q[0].a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic expect_pc(input logic [31:0] p, input int budget,
                             output int k);
        k = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            k++;
            if (s_valid && s_rdy) begin
                chk("pop_pc", s_pc, p);
                chk("pop_inst", s_inst, dat(p));
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL pop_timeout: no instruction within %0d cycles, expected pc %h",
                 budget, p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    vec_t vt[4];
    int   k, acc;

    initial begin
        vt[0] = '{rpc: 32'h0000_0103, pc0: 32'h0000_0100, pc1: 32'h0000_0104,
                  lat: 1, exp_k: 3};
        vt[1] = '{rpc: 32'hFFFF_FFFE, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000,
                  lat: 1, exp_k: 3};
        vt[2] = '{rpc: 32'h1000_0001, pc0: 32'h1000_0000, pc1: 32'h1000_0004,
                  lat: 2, exp_k: 4};
        vt[3] = '{rpc: 32'h0000_0ABC, pc0: 32'h0000_0ABC, pc1: 32'h0000_0AC0,
                  lat: 2, exp_k: 4};

        rst = 1'b1;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;

        // reset values
        do_reset();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_inst", s_inst, 32'd0);
        chk("rst_pc", s_pc, 32'd0);
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_addr", s_addr, 32'h0);

        // sequential streaming, 1-cycle memory
        lat = 1;
        expect_pc(32'h0, 10, k);
        chk("stream_first_k", k, 3);
        for (int i = 1; i < 8; i++) begin
            expect_pc(32'(i * 4), 5, k);
            chk("stream_k", k, 1);
        end

        // backpressure: credit limit of 4
        inst_ready = 1'b0;
        do_reset();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_req && s_gnt) acc++;
        end
        chk("bp_accepts", acc, 4);
        chk("bp_req_off", 32'(s_req), 32'd0);
        chk("bp_full_valid", 32'(s_valid), 32'd1);
        inst_ready = 1'b1;
        cycle();
        chk("bp_pop_pc", s_pc, 32'h0);
        inst_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_req && s_gnt) acc++;
        end
        chk("bp_refill", acc, 1);
        chk("bp_head_pc", s_pc, 32'h4);

        // mid-stream reset with a full FIFO
        rst = 1'b1;
        cycle();
        cycle();
        chk("mrst_valid", 32'(s_valid), 32'd0);
        chk("mrst_addr", s_addr, 32'h0);
        chk("mrst_req", 32'(s_req), 32'd0);
        rst = 1'b0;

        // three requests in flight, then redirect
        inst_ready = 1'b1;
        lat = 5;
        do_reset();
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (s_req && s_gnt) acc++;
        end
        chk("fl_accepts", acc, 3);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 1'b0;
        chk("fl_redir_req", 32'(s_req), 32'd0);
        expect_pc(32'h100, 20, k);
        expect_pc(32'h104, 20, k);

        // table: redirect during steady stream (rvalid and pop coincide)
        for (int v = 0; v < 4; v++) begin
            lat = vt[v].lat;
            for (int i = 0; i < 6; i++) cycle();
            redirect = 1'b1;
            redirect_pc = vt[v].rpc;
            cycle();
            redirect = 1'b0;
            chk("tv_pre_rv", 32'(s_rv), 32'd1);
            chk("tv_pre_valid", 32'(s_valid), 32'd1);
            chk("tv_redir_req", 32'(s_req), 32'd0);
            cycle();
            chk("tv_flush_valid", 32'(s_valid), 32'd0);
            expect_pc(vt[v].pc0, 10, k);
            chk("tv_latency", k + 1, vt[v].exp_k);
            expect_pc(vt[v].pc1, 10, k);
        end

        // back-to-back redirects: last one wins
        lat = 2;
        for (int i = 0; i < 6; i++) cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect_pc = 32'h0000_0300;
        cycle();
        redirect = 1'b0;
        expect_pc(32'h300, 10, k);
        expect_pc(32'h304, 10, k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
